// File: rtl/rc_charge_sequencer_if.sv
// Host-side control/result handshake for rc_charge_sequencer.
interface rc_charge_sequencer_if #(
  parameter int CNT_W = 16
) ();
  logic             start;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_cnt;
  logic             res_timeout;

  modport master (output start, res_ready, input busy, res_valid, res_cnt, res_timeout);
  modport slave  (input start, res_ready, output busy, res_valid, res_cnt, res_timeout);
endinterface

// File: rtl/rc_charge_sequencer.sv
// Discharge / charge / count sequencer for a series-R shunt-C test network.
// Optional RC_SEQ_DEGLITCH_EN: comparator must read high 3 clocks running before a trip counts.
module rc_charge_sequencer #(
  parameter int CNT_W      = 16,
  parameter int DIS_CYCLES = 64,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rc_charge_sequencer_if.slave  host,
  input  logic                  comp_hi,
  output logic                  chg_en,
  output logic                  dis_en
);
  localparam int DW = (DIS_CYCLES > 1) ? $clog2(DIS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO      = CNT_W'(TIMEOUT);
  localparam logic [DW-1:0]    DIS_END = DW'(DIS_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, DISCH, GAP, CHARGE, REPORT} state_t;

  state_t           state;
  logic [DW-1:0]    dcnt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             comp_m, comp_s, trip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {comp_s, comp_m} <= 2'b00;
    else        {comp_s, comp_m} <= {comp_m, comp_hi};
  end

`ifdef RC_SEQ_DEGLITCH_EN
  // Run length of high comparator samples seen inside the current CHARGE phase.
  logic [1:0] run;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         run <= 2'd0;
    else if (state == CHARGE && comp_s) run <= (run == 2'd2) ? run : run + 2'd1;
    else                                run <= 2'd0;
  end
  assign trip = comp_s && (run == 2'd2);
`else
  assign trip = comp_s;
`endif

  // The count includes the current CHARGE clock, so a trip on the first one reports 1.
  assign cnt_nxt = cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      dcnt             <= '0;
      cnt              <= '0;
      chg_en           <= 1'b0;
      dis_en           <= 1'b0;
      host.busy        <= 1'b0;
      host.res_valid   <= 1'b0;
      host.res_cnt     <= '0;
      host.res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (host.start) begin
          state     <= DISCH;
          host.busy <= 1'b1;
          dis_en    <= 1'b1;
          dcnt      <= '0;
          cnt       <= '0;
        end
        DISCH: begin
          if (dcnt == DIS_END) begin
            state  <= GAP;
            dis_en <= 1'b0;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        GAP: begin
          state  <= CHARGE;
          chg_en <= 1'b1;
        end
        CHARGE: begin
          if (trip || cnt_nxt == TO) begin
            state            <= REPORT;
            chg_en           <= 1'b0;
            host.res_valid   <= 1'b1;
            host.res_cnt     <= trip ? cnt_nxt : TO;
            host.res_timeout <= !trip;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        REPORT: begin
          // Bleed switch closes one clock after the charge switch opened.
          if (host.res_ready) begin
            state          <= IDLE;
            host.res_valid <= 1'b0;
            host.busy      <= 1'b0;
            dis_en         <= 1'b0;
          end else begin
            dis_en <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
